// File: rtl/connect_branch_pkg.sv
// connect_branch_pkg: destination-field helpers shared by the stream splitter and its producers.
`default_nettype none
package connect_branch_pkg;

    // Destination index is valid only when it names an existing output channel.
    function automatic logic dest_in_range(input int unsigned dest, input int unsigned num);
        return (dest < num);
    endfunction

    function automatic logic connect_num_ok(input int unsigned num, input int unsigned dest_width);
        return (num >= 2) && ((64'd1 << dest_width) >= 64'(num));
    endfunction

endpackage
`default_nettype wire

// File: rtl/connect_branch_if.sv
// connect_branch_if: one input stream, CONNECT_NUM output streams and the drop flag.
`default_nettype none
interface connect_branch_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int CONNECT_NUM = 3
);
    logic                              RECEIVE_VALID;
    logic [DATA_WIDTH-1:0]             RECEIVE_DATA;
    logic                              RECEIVE_READY;
    logic [CONNECT_NUM-1:0]            SEND_VALID;
    logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA;
    logic [CONNECT_NUM-1:0]            SEND_READY;
    logic                              DROP_ERROR;

    modport master (
        output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
        input  RECEIVE_READY, SEND_VALID, SEND_DATA, DROP_ERROR
    );

    modport slave (
        input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
        output RECEIVE_READY, SEND_VALID, SEND_DATA, DROP_ERROR
    );
endinterface
`default_nettype wire

// File: rtl/connect_branch_slot.sv
// connect_branch_slot: one-entry register slice with pass-through on drain.
`default_nettype none
module connect_branch_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  CLK,
    input  wire logic                  RST_N,
    input  wire logic                  load_i,
    input  wire logic [DATA_WIDTH-1:0] data_i,
    input  wire logic                  ready_i,
    output logic                       can_take_o,
    output logic                       full_o,
    output logic [DATA_WIDTH-1:0]      data_o
);
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    // A load wins over a drain, so a same-cycle load+drain keeps the slot full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (full_q && ready_i) begin
            full_d = 1'b0;
        end
    end

    assign can_take_o = !full_q || ready_i;
    assign full_o     = full_q;
    assign data_o     = data_q;
endmodule
`default_nettype wire

// File: rtl/connect_branch.sv
// connect_branch: 1-to-N stream splitter steering each beat by its destination field.
`default_nettype none
module connect_branch
    import connect_branch_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CONNECT_NUM = 3,
    parameter int DEST_LSB    = 0,
    parameter int DEST_WIDTH  = 2
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    connect_branch_if.slave   bus_if
);
    logic [DEST_WIDTH-1:0]  w_dest;
    logic                   w_in_range;
    logic                   w_sel_can_take;
    logic                   w_ready;
    logic [CONNECT_NUM-1:0] w_can_take;
    logic [CONNECT_NUM-1:0] w_load;
    logic                   drop_q, drop_d;

    assign w_dest     = bus_if.RECEIVE_DATA[DEST_LSB +: DEST_WIDTH];
    assign w_in_range = dest_in_range(32'(w_dest), CONNECT_NUM);

    // Ready mux is combinational from SEND_READY; out-of-range beats are always swallowed.
    always_comb begin
        w_sel_can_take = 1'b0;
        for (int i = 0; i < CONNECT_NUM; i++) begin
            if (w_dest == DEST_WIDTH'(i)) begin
                w_sel_can_take = w_can_take[i];
            end
        end
        w_ready = 1'b0;
        if (RST_N) begin
            w_ready = w_in_range ? w_sel_can_take : 1'b1;
        end
    end

    assign bus_if.RECEIVE_READY = w_ready;

    generate
        for (genvar g = 0; g < CONNECT_NUM; g++) begin : g_slot
            assign w_load[g] = bus_if.RECEIVE_VALID && w_ready && (w_dest == DEST_WIDTH'(g));

            connect_branch_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .CLK        (CLK),
                .RST_N      (RST_N),
                .load_i     (w_load[g]),
                .data_i     (bus_if.RECEIVE_DATA),
                .ready_i    (bus_if.SEND_READY[g]),
                .can_take_o (w_can_take[g]),
                .full_o     (bus_if.SEND_VALID[g]),
                .data_o     (bus_if.SEND_DATA[DATA_WIDTH*(g+1)-1 -: DATA_WIDTH])
            );
        end
    endgenerate

    always_comb begin
        drop_d = drop_q;
        if (bus_if.RECEIVE_VALID && w_ready && !w_in_range) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus_if.DROP_ERROR = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_connect_branch.sv
// tb_connect_branch: directed vectors for the 3-output splitter with hand-computed expectations.
`default_nettype none
module tb_connect_branch;
    localparam int DW = 32;
    localparam int CN = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    connect_branch_if #(.DATA_WIDTH(DW), .CONNECT_NUM(CN)) bus_if ();

    connect_branch #(
        .DATA_WIDTH  (DW),
        .CONNECT_NUM (CN),
        .DEST_LSB    (0),
        .DEST_WIDTH  (2)
    ) u_dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int i);
        return bus_if.SEND_DATA[DW*i +: DW];
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.RECEIVE_VALID = 1'b1;
        bus_if.RECEIVE_DATA  = 32'h10;
        bus_if.SEND_READY    = 3'b111;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rready", 32'(bus_if.RECEIVE_READY), 32'd0);
        check("rst_svalid", 32'(bus_if.SEND_VALID), 32'd0);
        check("rst_sdata", bus_if.SEND_DATA[31:0] | slice(1) | slice(2), 32'd0);
        check("rst_drop", 32'(bus_if.DROP_ERROR), 32'd0);

        // basic routing
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("b0_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        @(posedge clk); #1 bus_if.RECEIVE_DATA = 32'h21;
        @(negedge clk);
        check("b1_svalid", 32'(bus_if.SEND_VALID), 32'b001);
        check("b1_d0", slice(0), 32'h10);
        check("b1_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        @(posedge clk); #1 bus_if.RECEIVE_DATA = 32'h32;
        @(negedge clk);
        check("b2_svalid", 32'(bus_if.SEND_VALID), 32'b010);
        check("b2_d1", slice(1), 32'h21);
        check("b2_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        @(posedge clk); #1 bus_if.RECEIVE_VALID = 1'b0;
        @(negedge clk);
        check("b3_svalid", 32'(bus_if.SEND_VALID), 32'b100);
        check("b3_d2", slice(2), 32'h32);

        // backpressure isolation: out 0 stalled
        @(posedge clk); #1;
        bus_if.SEND_READY    = 3'b110;
        bus_if.RECEIVE_VALID = 1'b1;
        bus_if.RECEIVE_DATA  = 32'h100;
        @(negedge clk);
        check("bp0_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        @(posedge clk); #1 bus_if.RECEIVE_DATA = 32'h104;
        @(negedge clk);
        check("bp1_rready", 32'(bus_if.RECEIVE_READY), 32'd0);
        check("bp1_svalid", 32'(bus_if.SEND_VALID), 32'b001);
        check("bp1_d0", slice(0), 32'h100);
        @(posedge clk); #1 bus_if.RECEIVE_DATA = 32'h101;
        @(negedge clk);
        check("bp2_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        check("bp2_d0", slice(0), 32'h100);
        @(posedge clk); #1 bus_if.RECEIVE_VALID = 1'b0;
        @(negedge clk);
        check("bp3_svalid", 32'(bus_if.SEND_VALID), 32'b011);
        check("bp3_d1", slice(1), 32'h101);

        // pass-through: out 1 full and draining while a new beat arrives
        @(posedge clk); #1;
        bus_if.SEND_READY    = 3'b000;
        bus_if.RECEIVE_VALID = 1'b1;
        bus_if.RECEIVE_DATA  = 32'h201;
        @(posedge clk); #1;
        bus_if.SEND_READY    = 3'b010;
        bus_if.RECEIVE_DATA  = 32'h205;
        @(negedge clk);
        check("pt0_svalid", 32'(bus_if.SEND_VALID), 32'b011);
        check("pt0_d1", slice(1), 32'h201);
        check("pt0_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        @(posedge clk); #1;
        bus_if.RECEIVE_VALID = 1'b0;
        bus_if.SEND_READY    = 3'b000;
        @(negedge clk);
        check("pt1_svalid", 32'(bus_if.SEND_VALID), 32'b011);
        check("pt1_d1", slice(1), 32'h205);

        // out-of-range destination is dropped
        @(posedge clk); #1;
        bus_if.RECEIVE_VALID = 1'b1;
        bus_if.RECEIVE_DATA  = 32'h3;
        @(negedge clk);
        check("dr0_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        check("dr0_drop", 32'(bus_if.DROP_ERROR), 32'd0);
        @(posedge clk); #1 bus_if.RECEIVE_VALID = 1'b0;
        @(negedge clk);
        check("dr1_drop", 32'(bus_if.DROP_ERROR), 32'd1);
        check("dr1_svalid", 32'(bus_if.SEND_VALID), 32'b011);

        // fill all slots, then reset between edges
        @(posedge clk); #1;
        bus_if.RECEIVE_VALID = 1'b1;
        bus_if.RECEIVE_DATA  = 32'h302;
        @(posedge clk); #1 bus_if.RECEIVE_VALID = 1'b0;
        @(negedge clk);
        check("full_svalid", 32'(bus_if.SEND_VALID), 32'b111);
        check("full_d2", slice(2), 32'h302);
        check("full_drop", 32'(bus_if.DROP_ERROR), 32'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("ar_svalid", 32'(bus_if.SEND_VALID), 32'd0);
        check("ar_sdata", slice(0) | slice(1) | slice(2), 32'd0);
        check("ar_drop", 32'(bus_if.DROP_ERROR), 32'd0);
        check("ar_rready", 32'(bus_if.RECEIVE_READY), 32'd0);
        #2;
        rst_n = 1'b1;
        bus_if.SEND_READY    = 3'b111;
        bus_if.RECEIVE_VALID = 1'b1;
        bus_if.RECEIVE_DATA  = 32'h402;
        #1;
        check("rc_rready", 32'(bus_if.RECEIVE_READY), 32'd1);
        @(posedge clk); #1 bus_if.RECEIVE_VALID = 1'b0;
        @(negedge clk);
        check("rc_svalid", 32'(bus_if.SEND_VALID), 32'b100);
        check("rc_d2", slice(2), 32'h402);
        check("rc_drop", 32'(bus_if.DROP_ERROR), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
